// File: rtl/fifo_frame_pkg.sv
// Shared types and constants for the FIFO frame reader and its sample buffer.
package fifo_frame_pkg;

    typedef enum logic [0:0] {
        SAMPLE = 1'b0,
        CHECK  = 1'b1
    } out_state_e;

    localparam int FRAME_CNT_W = 16;

    // Width of the beat index; kept at least one bit so degenerate lengths still elaborate
    function automatic int idx_width(input int frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

endpackage

// File: rtl/sample_skid_buf.sv
// Two-entry sample buffer between the FIFO read port and the output stream.
// Writes land at the tail, pops shift the tail forward; head is always the oldest sample.
module sample_skid_buf
    import fifo_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk2,
    input  logic                  reset_n,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  pop_i,
    output logic [1:0]            occ_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;

    // The reader never writes into a full buffer nor pops an empty one
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({wr_en_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = wr_data_i;
                end else begin
                    tail_d = wr_data_i;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = wr_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = wr_data_i;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk2) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = head_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// Core-clock FIFO consumer that streams fixed-length frames with SOF/EOF and a frame counter.
// Build option FRAME_CHECKSUM_EN appends an XOR checksum beat (carrying EOF) to every frame.
module fifo_frame_reader
    import fifo_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 4
) (
    input  logic                   clk2,
    input  logic                   reset_n,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_data,
    output logic                   fifo_rd_en,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_sof,
    output logic                   m_eof,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int               IDX_W    = idx_width(FRAME_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    logic                   pending_q, pending_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]             occ;
    logic [DATA_WIDTH-1:0]  head;
    logic                   in_check;
    logic                   pop;
    logic                   buf_pop;
    logic                   last_sample;
    logic                   frame_done;
    logic [2:0]             occ_after;

    sample_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk2     (clk2),
        .reset_n  (reset_n),
        .wr_en_i  (pending_q),
        .wr_data_i(fifo_data),
        .pop_i    (buf_pop),
        .occ_o    (occ),
        .head_o   (head)
    );

    assign pop         = m_valid && m_ready;
    assign buf_pop     = pop && !in_check;
    assign last_sample = (idx_q == IDX_LAST);

    // Count the in-flight read as already buffered so at most two samples are ever owed to the buffer
    assign occ_after  = {1'b0, occ} + {2'b00, pending_q} - {2'b00, buf_pop};
    assign fifo_rd_en = reset_n && !fifo_empty && (occ_after < 3'd2);
    assign pending_d  = fifo_rd_en;

    assign m_valid = in_check || (occ != 2'd0);
    assign m_sof   = m_valid && !in_check && (idx_q == '0);

`ifdef FRAME_CHECKSUM_EN
    localparam logic [0:0] ST_SAMPLE = SAMPLE;
    localparam logic [0:0] ST_CHECK  = CHECK;

    logic [0:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;

    assign in_check   = (state_q == ST_CHECK);
    assign m_eof      = in_check;
    assign m_data     = in_check ? acc_q : head;
    assign frame_done = pop && in_check;

    // The accumulator restarts on the first sample, so the checksum beat needs no clearing step
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        if (buf_pop) begin
            acc_d = ((idx_q == '0) ? '0 : acc_q) ^ head;
            if (last_sample) begin
                state_d = ST_CHECK;
            end
        end else if (pop) begin
            state_d = ST_SAMPLE;
        end
    end

    always_ff @(posedge clk2) begin
        if (!reset_n) begin
            state_q <= ST_SAMPLE;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end
`else
    assign in_check   = 1'b0;
    assign m_eof      = m_valid && last_sample;
    assign m_data     = head;
    assign frame_done = buf_pop && last_sample;
`endif

    always_comb begin
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        if (buf_pop) begin
            idx_d = last_sample ? '0 : idx_q + IDX_W'(1);
        end
        if (frame_done) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk2) begin
        if (!reset_n) begin
            pending_q   <= 1'b0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            pending_q   <= pending_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Self-checking bench for fifo_frame_reader: behavioural FIFO plus a frame-level stream model.
// Honours FRAME_CHECKSUM_EN in the same way as the design.
module tb_fifo_frame_reader;

    localparam int DW = 8;
    localparam int FL = 4;
`ifdef FRAME_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif

    logic          clk2 = 1'b0;
    logic          reset_n;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_sof;
    logic          m_eof;
    logic [15:0]   frame_cnt;

    always #5 clk2 = ~clk2;

    fifo_frame_reader #(
        .DATA_WIDTH(DW),
        .FRAME_LEN (FL)
    ) dut (
        .clk2      (clk2),
        .reset_n   (reset_n),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_sof     (m_sof),
        .m_eof     (m_eof),
        .frame_cnt (frame_cnt)
    );

    int compared   = 0;
    int mismatched = 0;

    // FIFO contents not yet read, and samples read but not yet delivered downstream
    logic [DW-1:0] fifoQ[$];
    logic [DW-1:0] sampleQ[$];

    int            modelPos    = 0;
    logic [DW-1:0] modelAcc    = '0;
    logic [15:0]   modelFrames = '0;
    bit            sawReset    = 1'b0;

    logic          lastValid, lastSof, lastEof, lastRd;
    logic [DW-1:0] lastData;
    logic [DW-1:0] lastPopData;
    logic          lastPopSof, lastPopEof;
    bit            awaitingFirst = 1'b0;
    logic [DW-1:0] firstData;
    logic          firstSof;

    bit            holdArm = 1'b0;
    logic [DW-1:0] holdData;
    logic          holdSof, holdEof;

    int            readCount = 0;
    int            popCount  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Next expected beat derived from frame rules: SOF on sample 0, EOF on the frame's final beat
    task automatic modelPop();
        logic [DW-1:0] expData;
        logic          expSof, expEof;
        if (CKS && modelPos == FL) begin
            expData     = modelAcc;
            expSof      = 1'b0;
            expEof      = 1'b1;
            modelPos    = 0;
            modelFrames = modelFrames + 16'd1;
        end else begin
            compared++;
            assert (sampleQ.size() != 0) else begin
                mismatched++;
                $error("[TB] FAIL pop_has_sample: observed beat 0x%0h expected no beat", m_data);
            end
            if (sampleQ.size() == 0) return;
            expData  = sampleQ.pop_front();
            expSof   = (modelPos == 0);
            expEof   = !CKS && (modelPos == FL - 1);
            modelAcc = ((modelPos == 0) ? '0 : modelAcc) ^ expData;
            modelPos++;
            if (!CKS && modelPos == FL) begin
                modelPos    = 0;
                modelFrames = modelFrames + 16'd1;
            end
        end
        checkOutput("beat_data", lastData, expData);
        checkOutput("beat_sof", lastSof, expSof);
        checkOutput("beat_eof", lastEof, expEof);
        lastPopData = lastData;
        lastPopSof  = lastSof;
        lastPopEof  = lastEof;
        if (awaitingFirst) begin
            firstData     = lastData;
            firstSof      = lastSof;
            awaitingFirst = 1'b0;
        end
        popCount++;
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later, then model the FIFO read
    task automatic applyStimulus(input logic rstn, input logic rdy);
        logic accepted;
        reset_n    = rstn;
        m_ready    = rdy;
        fifo_empty = (fifoQ.size() == 0);
        #1;
        lastValid = m_valid;
        lastData  = m_data;
        lastSof   = m_sof;
        lastEof   = m_eof;
        lastRd    = fifo_rd_en;
        if (sawReset) checkOutput("frame_cnt", frame_cnt, modelFrames);
        if (fifo_empty) checkOutput("rd_en_while_empty", lastRd, 1'b0);
        if (!rstn) checkOutput("rd_en_in_reset", lastRd, 1'b0);
        if (holdArm) begin
            checkOutput("hold_valid", lastValid, 1'b1);
            checkOutput("hold_data", lastData, holdData);
            checkOutput("hold_sof", lastSof, holdSof);
            checkOutput("hold_eof", lastEof, holdEof);
        end
        holdArm  = rstn && (lastValid === 1'b1) && !rdy;
        holdData = lastData;
        holdSof  = lastSof;
        holdEof  = lastEof;
        accepted = (lastRd === 1'b1) && !fifo_empty;
        if (!rstn) begin
            sampleQ.delete();
            modelPos      = 0;
            modelFrames   = '0;
            awaitingFirst = 1'b1;
            sawReset      = 1'b1;
        end else if (lastValid === 1'b1 && rdy) begin
            modelPop();
        end
        @(posedge clk2);
        @(negedge clk2);
        if (accepted) begin
            fifo_data = fifoQ.pop_front();
            sampleQ.push_back(fifo_data);
            readCount++;
        end
    endtask

    task automatic drainAll(input int budget);
        int n = 0;
        while ((fifoQ.size() != 0 || sampleQ.size() != 0 || (CKS && modelPos == FL)) && n < budget) begin
            applyStimulus(1'b1, 1'b1);
            n++;
        end
        checkOutput("drain_done", fifoQ.size() + sampleQ.size(), 0);
    endtask

    initial begin
        int            base;
        int            pops0;
        int            fill;
        logic [DW-1:0] batch[6];

        reset_n    = 1'b0;
        m_ready    = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = '0;

        // Reset with a non-empty FIFO, then the first beat two cycles after release
        for (int i = 1; i <= 8; i++) fifoQ.push_back(8'(i));
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
        checkOutput("reset_rd_en", lastRd, 1'b0);
        checkOutput("reset_valid", lastValid, 1'b0);
        checkOutput("reset_data", lastData, 8'h00);
        checkOutput("reset_frame_cnt", frame_cnt, 16'd0);
        base = popCount;
        applyStimulus(1'b1, 1'b1);
        checkOutput("release_rd_en", lastRd, 1'b1);
        checkOutput("release_valid_t0", lastValid, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("release_valid_t1", lastValid, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("release_valid_t2", lastValid, 1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("stream_pops", popCount - base, 8);
        drainAll(20);
        checkOutput("stream_frames", frame_cnt, 16'd2);

        // Backpressure: only two reads may be owed while the sink stalls
        for (int i = 0; i < 6; i++) begin
            batch[i] = 8'($urandom);
            fifoQ.push_back(batch[i]);
        end
        base = readCount;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("stall_reads", readCount - base, 2);
        checkOutput("stall_valid", lastValid, 1'b1);
        checkOutput("stall_data", lastData, batch[0]);
        base = popCount;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("stall_release_pops", popCount - base, CKS ? 7 : 6);
        drainAll(20);

        // Empty boundary: FIFO runs dry after 0x03, the refill 0x04 closes the frame
        fill = (modelPos == 0) ? 0 : FL - modelPos;
        for (int i = 0; i < fill; i++) fifoQ.push_back(8'($urandom));
        for (int i = 1; i <= 3; i++) fifoQ.push_back(8'(i));
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("dry_rd_en", lastRd, 1'b0);
        checkOutput("dry_valid", lastValid, 1'b0);
        checkOutput("dry_last_data", lastPopData, 8'h03);
        fifoQ.push_back(8'h04);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1);
`ifdef FRAME_CHECKSUM_EN
        checkOutput("refill_cks_data", lastPopData, 8'h04);
        checkOutput("refill_cks_sof", lastPopSof, 1'b0);
`else
        checkOutput("refill_data", lastPopData, 8'h04);
`endif
        checkOutput("refill_eof", lastPopEof, 1'b1);

        // Reset mid-frame with a read in flight: the in-flight sample must vanish
        drainAll(20);
        for (int i = 0; i < 4; i++) fifoQ.push_back(8'hA1 + 8'(i));
        pops0 = popCount;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("midreset_pops", popCount - pops0, 2);
        applyStimulus(1'b0, 1'b1);
        checkOutput("midreset_frame_cnt", frame_cnt, 16'd0);
        for (int i = 0; i < 4; i++) fifoQ.push_back(8'hB1 + 8'(i));
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("midreset_first_data", firstData, 8'hB1);
        checkOutput("midreset_first_sof", firstSof, 1'b1);

        // Randomised traffic, sink stalls and occasional resets against the model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) != 0 && fifoQ.size() < 6) fifoQ.push_back(8'($urandom));
            applyStimulus(($urandom_range(0, 79) != 0), ($urandom_range(0, 3) != 0));
        end
        drainAll(60);

        // Known frame 0x11,0x22,0x44,0x88 from a clean start
        applyStimulus(1'b0, 1'b1);
        fifoQ.push_back(8'h11);
        fifoQ.push_back(8'h22);
        fifoQ.push_back(8'h44);
        fifoQ.push_back(8'h88);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1);
`ifdef FRAME_CHECKSUM_EN
        checkOutput("frame_cks_data", lastPopData, 8'hFF);
        checkOutput("frame_cks_sof", lastPopSof, 1'b0);
`else
        checkOutput("frame_last_data", lastPopData, 8'h88);
`endif
        checkOutput("frame_last_eof", lastPopEof, 1'b1);
        checkOutput("frame_count_one", frame_cnt, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
